// File: rtl/adjust_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adjust_ctrl
// Description : Adjust/run sequencer for the DE2 clock. Synchronises and
//               debounces the four active-low push keys, then runs a
//               RUN / ADJ_TIME / ADJ_DATE state machine that drives the
//               display adjust flag, the digit select and one-cycle inc/dec
//               strobes to the time core.
// Ports       : CLOCK_50   in   system clock (rising edge)
//               reset      in   asynchronous active-high reset
//               key_mode   in   raw key, active-low: RUN->ADJ_TIME->ADJ_DATE
//               key_next   in   raw key, active-low: next digit
//               key_inc    in   raw key, active-low: increment digit
//               key_dec    in   raw key, active-low: decrement digit
//               adjust     out  1 = run/normal display, 0 = adjusting
//               select     out  digit under adjustment (0 in RUN)
//               inc_pulse  out  one-cycle increment strobe
//               dec_pulse  out  one-cycle decrement strobe
// Revision    : 1.0  initial release
// ============================================================================
module adjust_ctrl #(
    parameter int unsigned DEB_CYCLES     = 1_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 1_500_000_000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       key_mode,
    input  logic       key_next,
    input  logic       key_inc,
    input  logic       key_dec,
    output logic       adjust,
    output logic [3:0] select,
    output logic       inc_pulse,
    output logic       dec_pulse
);

    // Counter widths never shrink below what the default parameters need.
    localparam int c_DEB_W  = ($clog2(DEB_CYCLES) > 20) ? $clog2(DEB_CYCLES) : 20;
    localparam int c_IDLE_W = ($clog2(TIMEOUT_CYCLES) > 31) ? $clog2(TIMEOUT_CYCLES) : 31;
    localparam logic [c_DEB_W-1:0]  c_DEB_LAST  = c_DEB_W'(DEB_CYCLES - 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_ADJ_TIME = 2'd1,
        ST_ADJ_DATE = 2'd2
    } state_t;

    // Key index: 3 = mode, 2 = next, 1 = inc, 0 = dec
    logic [3:0] w_raw;
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] w_press;

    assign w_raw = {key_mode, key_next, key_inc, key_dec};

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_deb
            logic [c_DEB_W-1:0] r_cnt;
            logic               r_stable;
            logic               r_stable_d;

            always_ff @(posedge CLOCK_50 or posedge reset) begin
                if (reset) begin
                    r_cnt      <= '0;
                    r_stable   <= 1'b1;
                    r_stable_d <= 1'b1;
                end else begin
                    r_stable_d <= r_stable;
                    if (r_sync2[gi] == r_stable) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_DEB_LAST) begin
                        r_stable <= r_sync2[gi];
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_DEB_W'(1);
                    end
                end
            end

            // Falling edge of the accepted level; releases give no event.
            assign w_press[gi] = r_stable_d & ~r_stable;
        end
    endgenerate

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_select;
    logic [3:0]          w_select_nxt;
    logic                r_adjust;
    logic                w_adjust_nxt;
    logic                r_inc;
    logic                w_inc_nxt;
    logic                r_dec;
    logic                w_dec_nxt;
    logic [c_IDLE_W-1:0] r_idle;
    logic [c_IDLE_W-1:0] w_idle_nxt;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state  <= ST_RUN;
            r_select <= 4'd0;
            r_adjust <= 1'b1;
            r_inc    <= 1'b0;
            r_dec    <= 1'b0;
            r_idle   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_select <= w_select_nxt;
            r_adjust <= w_adjust_nxt;
            r_inc    <= w_inc_nxt;
            r_dec    <= w_dec_nxt;
            r_idle   <= w_idle_nxt;
        end
    end

    // Event priority within one cycle: mode > next > inc > dec; losers dropped.
    always_comb begin
        w_state_nxt  = r_state;
        w_select_nxt = r_select;
        w_inc_nxt    = 1'b0;
        w_dec_nxt    = 1'b0;
        w_idle_nxt   = r_idle + c_IDLE_W'(1);

        case (r_state)
            ST_RUN: begin
                w_idle_nxt = '0;
                if (w_press[3]) begin
                    w_state_nxt  = ST_ADJ_TIME;
                    w_select_nxt = 4'd7;
                end
            end
            ST_ADJ_TIME: begin
                if (w_press[3]) begin
                    w_state_nxt  = ST_ADJ_DATE;
                    w_select_nxt = 4'd11;
                end else if (w_press[2]) begin
                    // 7..2 wrap; the millisecond digits are never selected
                    w_select_nxt = (r_select == 4'd2) ? 4'd7 : r_select - 4'd1;
                end else if (w_press[1]) begin
                    w_inc_nxt = 1'b1;
                end else if (w_press[0]) begin
                    w_dec_nxt = 1'b1;
                end else if (r_idle == c_IDLE_LAST) begin
                    w_state_nxt  = ST_RUN;
                    w_select_nxt = 4'd0;
                end
            end
            ST_ADJ_DATE: begin
                if (w_press[3]) begin
                    w_state_nxt  = ST_RUN;
                    w_select_nxt = 4'd0;
                end else if (w_press[2]) begin
                    // Left-to-right: month/day 11..8, then year 15..12
                    if (r_select == 4'd8) begin
                        w_select_nxt = 4'd15;
                    end else if (r_select == 4'd12) begin
                        w_select_nxt = 4'd11;
                    end else begin
                        w_select_nxt = r_select - 4'd1;
                    end
                end else if (w_press[1]) begin
                    w_inc_nxt = 1'b1;
                end else if (w_press[0]) begin
                    w_dec_nxt = 1'b1;
                end else if (r_idle == c_IDLE_LAST) begin
                    w_state_nxt  = ST_RUN;
                    w_select_nxt = 4'd0;
                end
            end
            default: begin
                w_state_nxt  = ST_RUN;
                w_select_nxt = 4'd0;
            end
        endcase

        if ((|w_press) || (w_state_nxt != r_state)) begin
            w_idle_nxt = '0;
        end

        w_adjust_nxt = (w_state_nxt == ST_RUN);
    end

    assign adjust    = r_adjust;
    assign select    = r_select;
    assign inc_pulse = r_inc;
    assign dec_pulse = r_dec;

endmodule
`default_nettype wire

// File: tb/tb_adjust_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_adjust_ctrl
// Description : Self-checking bench for adjust_ctrl. A behavioural model
//               (key history windows, digit-order tables) is compared with
//               the DUT every cycle; directed sequences and a vector table
//               check latency, bounce rejection, priority and timeout.
// Revision    : 1.0  initial release
// ============================================================================
module tb_adjust_ctrl;

    localparam int DEB = 4;
    localparam int TO  = 100;
    localparam int TORD [6] = '{7, 6, 5, 4, 3, 2};
    localparam int DORD [8] = '{11, 10, 9, 8, 15, 14, 13, 12};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] keys = 4'hF;   // 3 mode, 2 next, 1 inc, 0 dec (active low)
    logic       adjust;
    logic [3:0] select;
    logic       inc_pulse;
    logic       dec_pulse;

    int n_cmp = 0;
    int n_bad = 0;
    int n_inc = 0;
    int n_dec = 0;
    bit chk_en = 1'b0;

    adjust_ctrl #(
        .DEB_CYCLES     (DEB),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .CLOCK_50  (clk),
        .reset     (rst),
        .key_mode  (keys[3]),
        .key_next  (keys[2]),
        .key_inc   (keys[1]),
        .key_dec   (keys[0]),
        .adjust    (adjust),
        .select    (select),
        .inc_pulse (inc_pulse),
        .dec_pulse (dec_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        keys = ~mask;
        tick(hold);
        keys = 4'hF;
        tick(8);
    endtask

    // ---------------- behavioural reference model ----------------
    // A key's accepted level flips once the last DEB synchronised samples
    // (raw samples 2..DEB+1 edges old) all disagree with it; the press is
    // seen by the sequencer on the following edge.
    logic [15:0] m_hist [4];
    logic [3:0]  m_st;
    logic [3:0]  m_pend;
    int          m_mode;   // 0 run, 1 time, 2 date
    int          m_idx;
    int          m_idle;
    logic        m_inc;
    logic        m_dec;

    function automatic int m_sel();
        if (m_mode == 1) return TORD[m_idx];
        if (m_mode == 2) return DORD[m_idx];
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin : m_step
        logic [3:0]     ev;
        logic [DEB-1:0] win;
        if (rst) begin
            for (int k = 0; k < 4; k++) m_hist[k] = 16'hFFFF;
            m_st = 4'hF; m_pend = 4'h0;
            m_mode = 0; m_idx = 0; m_idle = 0; m_inc = 1'b0; m_dec = 1'b0;
        end else begin
            ev = m_pend;
            m_inc = 1'b0;
            m_dec = 1'b0;
            if (m_mode == 0) begin
                m_idle = 0;
                if (ev[3]) begin m_mode = 1; m_idx = 0; end
            end else if (ev != 4'h0) begin
                m_idle = 0;
                if (ev[3]) begin
                    m_mode = (m_mode == 1) ? 2 : 0;
                    m_idx  = 0;
                end else if (ev[2]) m_idx = (m_idx + 1) % ((m_mode == 1) ? 6 : 8);
                else if (ev[1]) m_inc = 1'b1;
                else m_dec = 1'b1;
            end else if (m_idle == TO - 1) begin
                m_mode = 0; m_idle = 0;
            end else begin
                m_idle++;
            end
            for (int k = 0; k < 4; k++) begin
                m_hist[k] = {m_hist[k][14:0], keys[k]};
                win = m_hist[k][DEB+1:2];
                m_pend[k] = 1'b0;
                if (win == (m_st[k] ? {DEB{1'b0}} : {DEB{1'b1}})) begin
                    m_st[k]   = ~m_st[k];
                    m_pend[k] = ~m_st[k];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && chk_en) begin
            check("model", {adjust, select, inc_pulse, dec_pulse},
                  {(m_mode == 0), 4'(m_sel()), m_inc, m_dec});
            if (inc_pulse || dec_pulse)
                check("strobe_legal", {inc_pulse & dec_pulse, adjust}, 0);
            n_inc += int'(inc_pulse);
            n_dec += int'(dec_pulse);
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] press;
        int         hold;
        logic       adj;
        logic [3:0] sel;
        int         ninc;
        int         ndec;
    } vec_t;

    vec_t tbl [15];

    initial begin
        tbl[0]  = '{4'b1000, 10, 1'b0, 4'd7,  0, 0};  // mode -> ADJ_TIME
        tbl[1]  = '{4'b0100, 10, 1'b0, 4'd6,  0, 0};
        tbl[2]  = '{4'b0100, 10, 1'b0, 4'd5,  0, 0};
        tbl[3]  = '{4'b0010, 50, 1'b0, 4'd5,  1, 0};  // held inc: one strobe
        tbl[4]  = '{4'b0011, 10, 1'b0, 4'd5,  1, 0};  // inc beats dec
        tbl[5]  = '{4'b1100, 10, 1'b0, 4'd11, 0, 0};  // mode beats next
        tbl[6]  = '{4'b0100, 10, 1'b0, 4'd10, 0, 0};
        tbl[7]  = '{4'b0001, 10, 1'b0, 4'd10, 0, 1};
        tbl[8]  = '{4'b1000, 10, 1'b1, 4'd0,  0, 0};  // back to RUN
        tbl[9]  = '{4'b0100, 10, 1'b1, 4'd0,  0, 0};  // ignored in RUN
        tbl[10] = '{4'b0010, 10, 1'b1, 4'd0,  0, 0};
        tbl[11] = '{4'b0001, 10, 1'b1, 4'd0,  0, 0};
        tbl[12] = '{4'b1010, 10, 1'b0, 4'd7,  0, 0};  // mode wins, no strobe
        tbl[13] = '{4'b1000, 10, 1'b0, 4'd11, 0, 0};
        tbl[14] = '{4'b1000, 10, 1'b1, 4'd0,  0, 0};
    end

    initial begin
        int dur;
        tick(3);
        rst = 1'b0;
        chk_en = 1'b1;

        // reset state
        check("rst_adjust", adjust, 1);
        check("rst_select", select, 0);
        check("rst_strobes", {inc_pulse, dec_pulse}, 0);

        // bounce rejected, then exact first-response latency
        keys[3] = 1'b0; tick(3); keys[3] = 1'b1; tick(12);
        check("bounce_adjust", adjust, 1);
        keys[3] = 1'b0;
        tick(DEB + 2);
        check("lat_early_adjust", adjust, 1);
        tick(1);
        check("lat_adjust", adjust, 0);
        check("lat_select", select, 7);
        tick(3); keys[3] = 1'b1; tick(10);

        // digit walk in both adjust states
        for (int i = 0; i < 6; i++) begin
            press(4'b0100, 8);
            check($sformatf("time_next%0d", i), select, TORD[(i + 1) % 6]);
        end
        press(4'b1000, 8);
        check("to_date_select", select, 11);
        for (int i = 0; i < 8; i++) begin
            press(4'b0100, 8);
            check($sformatf("date_next%0d", i), select, DORD[(i + 1) % 8]);
        end
        press(4'b1000, 8);
        check("to_run_adjust", adjust, 1);

        // table-driven vectors
        for (int i = 0; i < 15; i++) begin
            n_inc = 0; n_dec = 0;
            press(tbl[i].press, tbl[i].hold);
            check($sformatf("vec%0d_adjust", i), adjust, tbl[i].adj);
            check($sformatf("vec%0d_select", i), select, tbl[i].sel);
            check($sformatf("vec%0d_inc", i), n_inc, tbl[i].ninc);
            check($sformatf("vec%0d_dec", i), n_dec, tbl[i].ndec);
        end

        // timeout: press in the last idle cycle wins, then a full timeout
        keys[3] = 1'b0;
        tick(7);                     // now at entry edge E (+1)
        check("tmo_enter_select", select, 7);
        tick(3); keys[3] = 1'b1;
        tick(89); keys[2] = 1'b0;    // first low sample at E+94
        tick(6);
        check("tmo_edge_adjust", adjust, 0);
        check("tmo_edge_select", select, 7);
        tick(1);
        check("tmo_press_wins", {adjust, select}, {1'b0, 4'd6});
        tick(2); keys[2] = 1'b1;
        tick(97);
        check("tmo_before", {adjust, select}, {1'b0, 4'd6});
        tick(1);
        check("tmo_fired", {adjust, select}, {1'b1, 4'd0});

        // asynchronous reset in the middle of ADJ_DATE
        press(4'b1000, 8); press(4'b1000, 8);
        press(4'b0100, 8); press(4'b0100, 8);
        check("pre_rst_select", select, 9);
        #3 rst = 1'b1;
        #1;
        check("async_rst", {adjust, select, inc_pulse, dec_pulse}, {1'b1, 4'd0, 1'b0, 1'b0});
        tick(2);
        rst = 1'b0;
        tick(2);

        // randomized key activity against the model
        for (int s = 0; s < 150; s++) begin
            if ($urandom_range(0, 9) == 0) begin
                keys = 4'hF;
                dur  = $urandom_range(50, 130);
            end else begin
                keys = 4'($urandom) | 4'($urandom);
                dur  = $urandom_range(1, 14);
            end
            tick(dur);
        end
        keys = 4'hF;
        tick(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
